band_energy_accumulator: RTL

BAND_ENERGY_ACCUMULATOR -- requirements
Module: band_energy_accumulator

---
 rtl/band_energy_accumulator.sv | 104 ++++++++++
 1 files changed

// File: rtl/band_energy_accumulator.sv
// Three-band windowed energy accumulator with saturating 32-bit sums.
// Define BAND_ENERGY_SQUARE_EN for sample*sample terms; default is |sample|.
module band_energy_accumulator #(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int WINDOW_SAMPLES = 1024,
    parameter int OUT_SHIFT      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] low_sample,
    input  logic signed [SAMPLE_WIDTH-1:0] mid_sample,
    input  logic signed [SAMPLE_WIDTH-1:0] high_sample,
    output logic        [31:0]             low_data,
    output logic        [31:0]             mid_data,
    output logic        [31:0]             high_data,
    output logic                           update_face,
    output logic        [15:0]             sample_count
);

    localparam logic [15:0] LAST_IDX = 16'(WINDOW_SAMPLES - 1);
    localparam logic [SAMPLE_WIDTH-1:0] ONE = SAMPLE_WIDTH'(1);

    // Magnitude is taken as unsigned so the most negative input maps to
    // 2^(SAMPLE_WIDTH-1) without wrapping.
    function automatic logic [31:0] band_term(
        input logic [SAMPLE_WIDTH-1:0] s
    );
        logic [SAMPLE_WIDTH-1:0] mag;
        logic [31:0]             mag32;
        mag   = s[SAMPLE_WIDTH-1] ? ((~s) + ONE) : s;
        mag32 = 32'(mag);
`ifdef BAND_ENERGY_SQUARE_EN
        return mag32 * mag32;
`else
        return mag32;
`endif
    endfunction

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [2:0][SAMPLE_WIDTH-1:0] smp;
    logic [2:0][31:0]             sum;
    logic [2:0][31:0]             acc_q, acc_d;
    logic [2:0][31:0]             data_q, data_d;
    logic [15:0]                  cnt_q, cnt_d;
    logic                         upd_q, upd_d;
    logic                         close;

    assign smp   = {high_sample, mid_sample, low_sample};
    assign close = sample_valid && (cnt_q == LAST_IDX);

    always_comb begin
        for (int b = 0; b < 3; b++) begin
            sum[b] = sat_add(acc_q[b], band_term(smp[b]));
        end
    end

    always_comb begin
        acc_d  = acc_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        upd_d  = 1'b0;
        if (close) begin
            for (int b = 0; b < 3; b++) begin
                data_d[b] = sum[b] >> OUT_SHIFT;
                acc_d[b]  = '0;
            end
            cnt_d = '0;
            upd_d = 1'b1;
        end else if (sample_valid) begin
            acc_d = sum;
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            upd_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            upd_q  <= upd_d;
        end
    end

    assign low_data     = data_q[0];
    assign mid_data     = data_q[1];
    assign high_data    = data_q[2];
    assign update_face  = upd_q;
    assign sample_count = cnt_q;

endmodule
